// File: rtl/instruction_loader.sv
// Packs a valid/ready byte stream into 32-bit little-endian words and writes
// them into the instruction memory, flagging completion or overflow.
module instruction_loader #(
    parameter int SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] word_count,
    output logic        load_done,
    output logic        load_error
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    localparam logic [31:0] SIZE_W = 32'(SIZE);

    logic [2:0]  state;
    logic [1:0]  lane;
    logic        last_seen;
    logic [31:0] word;
    logic        room;

    assign room = (word_count < SIZE_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= 2'd0;
            last_seen  <= 1'b0;
            word       <= 32'd0;
            word_count <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= COLLECT;
                        lane       <= 2'd0;
                        last_seen  <= 1'b0;
                        word       <= 32'd0;
                        word_count <= 32'd0;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        word[{lane, 3'b000} +: 8] <= byte_in;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3 || byte_last) begin
                            state     <= WRITE;
                            last_seen <= byte_last;
                        end
                    end
                end
                WRITE: begin
                    if (room) begin
                        word_count <= word_count + 32'd1;
                        lane       <= 2'd0;
                        // Cleared so a short final word is zero-padded in its upper lanes.
                        word       <= 32'd0;
                        state      <= last_seen ? DONE : COLLECT;
                    end else begin
                        state <= ERROR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == COLLECT);
    assign wr_en      = (state == WRITE) && room;
    assign wr_addr    = {word_count[29:0], 2'b00};
    assign wr_data    = word;
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);
endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: a byte-packing model queues the
// expected writes, and a write monitor pops and compares them.
module tb_instruction_loader;
    localparam int SIZE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] word_count;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_acc;
    int          m_lane;
    int          m_widx;
    bit          in_load = 1'b0;
    int          rlow = 0;

    instruction_loader #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .word_count(word_count),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", wr_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
        if (in_load && !byte_ready && !load_done && !load_error) rlow++;
    end

    task automatic begin_load();
        m_acc = 32'd0; m_lane = 0; m_widx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_load = 1'b1; rlow = 0;
    endtask

    // Offers one byte until accepted; the model records the word it completes.
    task automatic send(input logic [7:0] b, input bit last, input bit st);
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            byte_in = b; byte_valid = 1'b1; byte_last = last; start = st;
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        m_acc[m_lane*8 +: 8] = b;
        m_lane++;
        if (m_lane == 4 || last) begin
            if (m_widx < SIZE) exp_q.push_back({32'(m_widx * 4), m_acc});
            m_widx++;
            m_acc = 32'd0; m_lane = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
        end
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        idle_cycles(1);
        for (int t = 0; t < 50 && !seen; t++) begin
            if (load_done || load_error) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("end_timeout", 32'd0, 32'd1);
        in_load = 1'b0;
    endtask

    task automatic send_seq(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) send(first + 8'(i), i == n - 1, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr"}, wr_addr, 32'd0);
        chk({tag, "_data"}, wr_data, 32'd0);
        chk({tag, "_wc"}, word_count, 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("rst");
        @(negedge clk); reset = 1'b0;

        // Single instruction word
        begin_load();
        send(8'h13, 0, 0); send(8'h00, 0, 0); send(8'h50, 0, 0); send(8'h00, 1, 0);
        wait_end();
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_err", 32'(load_error), 32'd0);
        chk("t1_wc", word_count, 32'd1);
        chk("t1_q", 32'(exp_q.size()), 32'd0);

        // Three back-to-back words, restart from DONE
        begin_load();
        send_seq(12, 8'h20);
        wait_end();
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_wc", word_count, 32'd3);
        chk("t2_ready_low", 32'(rlow), 32'd3);
        chk("t2_q", 32'(exp_q.size()), 32'd0);

        // Short final word is zero-padded
        begin_load();
        send_seq(6, 8'h01);
        wait_end();
        chk("t3_done", 32'(load_done), 32'd1);
        chk("t3_wc", word_count, 32'd2);
        chk("t3_q", 32'(exp_q.size()), 32'd0);

        // Exactly SIZE words
        begin_load();
        send_seq(16, 8'h40);
        wait_end();
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_err", 32'(load_error), 32'd0);
        chk("t4_wc", word_count, 32'd4);
        chk("t4_q", 32'(exp_q.size()), 32'd0);

        // One byte past SIZE words
        begin_load();
        send_seq(17, 8'h80);
        wait_end();
        chk("t5_err", 32'(load_error), 32'd1);
        chk("t5_done", 32'(load_done), 32'd0);
        chk("t5_wc", word_count, 32'd4);
        chk("t5_q", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a word
        begin_load();
        send(8'hAA, 0, 0); send(8'hBB, 0, 0);
        @(negedge clk); byte_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 chk_reset_vals("mid");
        @(negedge clk); reset = 1'b0;
        in_load = 1'b0;
        idle_cycles(2);
        chk("mid_q", 32'(exp_q.size()), 32'd0);
        begin_load();
        send(8'h37, 0, 0); send(8'h01, 0, 0); send(8'h00, 0, 0); send(8'h00, 1, 0);
        wait_end();
        chk("mid_wc", word_count, 32'd1);
        chk("mid_q2", 32'(exp_q.size()), 32'd0);

        // Gaps in valid plus a start pulse while collecting
        begin_load();
        for (int i = 0; i < 7; i++) begin
            idle_cycles(i % 3);
            send(8'hC0 + 8'(i), i == 6, i == 2 || i == 5);
        end
        wait_end();
        chk("t7_done", 32'(load_done), 32'd1);
        chk("t7_wc", word_count, 32'd2);
        chk("t7_q", 32'(exp_q.size()), 32'd0);

        idle_cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
